shift_add_multiplier: RTL and testbench

- Sequential unsigned N x N -> 2N multiplier.
- Drives one N-bit ripple_carry adder instance with partial-product operands and consumes its sum and carry every cycle.
- Acts as the stage directly upstream and downstream of the adder.
- Operands and result use valid/ready handshakes so the block can sit between operand and result queues.

---
 rtl/mul_pkg.sv | 15 +
 rtl/ripple_carry.sv | 23 ++
 rtl/shift_add_multiplier.sv | 127 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Width of a down-counter that must hold the value n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ripple_carry.sv
// N-bit ripple-carry adder: o_o/c_o = a_i + b_i + c_i.
module ripple_carry #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] o_o,
    output logic         c_o
);

    logic [N:0] carry;

    assign carry[0] = c_i;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign o_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = carry[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N shift-add multiplier with valid/ready handshakes.
// Optional early termination when SHIFT_ADD_MUL_EARLY_TERM_EN is defined.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*N-1:0] p_o
);

    localparam int CW = cnt_width(N);

    mul_state_e     state_q;
    logic [N-1:0]   mcand_q;
    logic [2*N-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [2*N-1:0] p_q;

    logic [N-1:0]   add_b;
    logic [N-1:0]   add_sum;
    logic           add_co;
    logic [2*N-1:0] acc_d;
    logic           last_d;

    assign add_b = acc_q[0] ? mcand_q : '0;

    ripple_carry #(.N(N)) u_adder (
        .a_i (acc_q[2*N-1:N]),
        .b_i (add_b),
        .c_i (1'b0),
        .o_o (add_sum),
        .c_o (add_co)
    );

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    logic [N-1:0] rem_mask;
    logic         early_done;

    // Only the low cnt_q bits of acc still hold unprocessed multiplier bits.
    always_comb begin
        rem_mask = '0;
        for (int i = 0; i < N; i++) begin
            rem_mask[i] = (CW'(i) < cnt_q);
        end
        early_done = ((acc_q[N-1:0] & rem_mask) == '0);
    end
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        acc_d  = {add_co, add_sum, acc_q[N-1:1]};
        last_d = (cnt_q == CW'(1));
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        // Remaining steps would all add zero, so collapse them into one shift.
        if (early_done) begin
            acc_d  = acc_q >> cnt_q;
            last_d = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            p_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        mcand_q    <= a_i;
                        acc_q      <= {{N{1'b0}}, b_i};
                        cnt_q      <= CW'(N);
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_d) begin
                        p_q         <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        p_q         <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mcand_q     <= '0;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    p_q         <= '0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign p_o         = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random self-checking bench for shift_add_multiplier (N=8).
module tb_shift_add_multiplier;

    localparam int N = 8;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [N-1:0]   a_i;
    logic [N-1:0]   b_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [2*N-1:0] p_o;

    int checks   = 0;
    int failures = 0;

    shift_add_multiplier #(.N(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .p_o         (p_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one product with out_ready_i low until valid appears; lat is edges from accept to valid, -1 on timeout.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] p, output int lat);
        int guard;
        guard = 0;
        lat = -1;
        p = '0;
        while (!in_ready_o && guard < 50) begin
            tick();
            guard++;
        end
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        a_i = a;
        b_i = b;
        tick();
        in_valid_i = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid_o) begin
                lat = i;
                p = p_o;
                break;
            end
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        a_i = 8'h33;
        b_i = 8'h44;
        tick();
        tick();
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || p_o !== 16'h0000) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b p=%h, required 1 0 0000", in_ready_o, out_valid_o, p_o);
        end
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int lat;
        do_op(8'h06, 8'h06, p, lat);
        checks++;
        if (p !== 16'h0024) begin
            failures++;
            $display("FAIL basic_6x6: p=%h required 0024", p);
        end
        checks++;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        if (lat < 1 || lat > N) begin
`else
        if (lat != N) begin
`endif
            failures++;
            $display("FAIL basic_latency: got %0d edges, required %0d", lat, N);
        end
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || p_o !== 16'h0000) begin
            failures++;
            $display("FAIL basic_return_idle: in_ready=%b out_valid=%b p=%h, required 1 0 0000", in_ready_o, out_valid_o, p_o);
        end
    endtask

    task automatic test_carry();
        logic [15:0] p;
        int lat;
        do_op(8'hFF, 8'hFF, p, lat);
        checks++;
        if (p !== 16'hFE01) begin
            failures++;
            $display("FAIL carry_ffxff: p=%h required fe01", p);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  va [6] = '{8'h80, 8'h00, 8'h01, 8'hFF, 8'h01, 8'hAA};
        logic [7:0]  vb [6] = '{8'h02, 8'hFF, 8'h01, 8'h01, 8'h80, 8'h55};
        logic [15:0] ve [6] = '{16'h0100, 16'h0000, 16'h0001, 16'h00FF, 16'h0080, 16'h3872};
        logic [15:0] p;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], p, lat);
            checks++;
            if (p !== ve[i] || lat < 0) begin
                failures++;
                $display("FAIL corner_%0d: %h*%h p=%h lat=%0d, required %h", i, va[i], vb[i], p, lat, ve[i]);
            end
        end
        do_op(8'hFF, 8'h00, p, lat);
        checks++;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        if (p !== 16'h0000 || lat != 1) begin
            failures++;
            $display("FAIL zero_multiplier: p=%h lat=%0d, required 0000 lat 1", p, lat);
        end
`else
        if (p !== 16'h0000 || lat != N) begin
            failures++;
            $display("FAIL zero_multiplier: p=%h lat=%0d, required 0000 lat %0d", p, lat, N);
        end
`endif
    endtask

    task automatic test_backpressure();
        int guard;
        bit stable_ok;
        guard = 0;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        a_i = 8'h12;
        b_i = 8'h34;
        tick();
        a_i = 8'h55;
        b_i = 8'h55;
        while (!out_valid_o && guard < 40) begin
            tick();
            guard++;
        end
        stable_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || p_o !== 16'h03A8) stable_ok = 1'b0;
            tick();
        end
        checks++;
        if (!stable_ok || out_valid_o !== 1'b1 || p_o !== 16'h03A8) begin
            failures++;
            $display("FAIL backpressure_hold: out_valid=%b in_ready=%b p=%h, required 1 0 03a8 throughout", out_valid_o, in_ready_o, p_o);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || p_o !== 16'h0000) begin
            failures++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b p=%h, required 0 1 0000", out_valid_o, in_ready_o, p_o);
        end
        tick();
        in_valid_i = 1'b0;
        guard = 0;
        while (!out_valid_o && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (out_valid_o !== 1'b1 || p_o !== 16'h1C39) begin
            failures++;
            $display("FAIL backpressure_next: out_valid=%b p=%h, required 1 1c39", out_valid_o, p_o);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic [15:0] p;
        int lat;
        bit quiet;
        out_ready_i = 1'b1;
        in_valid_i = 1'b1;
        a_i = 8'hAB;
        b_i = 8'hCD;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || p_o !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_busy: in_ready=%b out_valid=%b p=%h, required 1 0 0000", in_ready_o, out_valid_o, p_o);
        end
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid_o !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL reset_discard: out_valid seen after reset, required no stale product");
        end
        do_op(8'h0F, 8'h11, p, lat);
        checks++;
        if (p !== 16'h00FF || lat < 0) begin
            failures++;
            $display("FAIL after_reset_op: p=%h lat=%0d, required 00ff", p, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [3] = '{8'h03, 8'h07, 8'hC8};
        logic [7:0]  vb [3] = '{8'h05, 8'h09, 8'h03};
        logic [15:0] ve [3] = '{16'h000F, 16'h003F, 16'h0258};
        int acc_cycle [3];
        int n_acc, n_out, cyc;
        bit acc_now;
        n_acc = 0;
        n_out = 0;
        cyc = 0;
        out_ready_i = 1'b1;
        in_valid_i = 1'b1;
        a_i = va[0];
        b_i = vb[0];
        while (n_out < 3 && cyc < 200) begin
            acc_now = in_valid_i && in_ready_o;
            if (out_valid_o) begin
                checks++;
                if (p_o !== ve[n_out]) begin
                    failures++;
                    $display("FAIL b2b_product_%0d: p=%h required %h", n_out, p_o, ve[n_out]);
                end
                n_out++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                acc_cycle[n_acc] = cyc;
                n_acc++;
                if (n_acc < 3) begin
                    a_i = va[n_acc];
                    b_i = vb[n_acc];
                end else begin
                    in_valid_i = 1'b0;
                end
            end
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        checks++;
        if (n_out != 3 || n_acc != 3) begin
            failures++;
            $display("FAIL b2b_count: accepted=%0d produced=%0d, required 3 3", n_acc, n_out);
        end
`ifndef SHIFT_ADD_MUL_EARLY_TERM_EN
        else begin
            checks++;
            if (acc_cycle[1] - acc_cycle[0] != N + 2 || acc_cycle[2] - acc_cycle[1] != N + 2) begin
                failures++;
                $display("FAIL b2b_throughput: spacing %0d %0d, required %0d", acc_cycle[1] - acc_cycle[0], acc_cycle[2] - acc_cycle[1], N + 2);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] exp_q [$];
        logic [15:0] exp_p;
        logic [15:0] snap_p;
        int n_acc, n_out, cyc, bad;
        bit acc_now, cons_now;
        n_acc = 0;
        n_out = 0;
        cyc = 0;
        bad = 0;
        a_i = 8'($urandom_range(0, 255));
        b_i = 8'($urandom_range(0, 255));
        while (n_out < 1000 && cyc < 60000) begin
            in_valid_i  = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 9) < 7);
            acc_now  = in_valid_i && in_ready_o;
            cons_now = out_valid_o && out_ready_i;
            snap_p   = p_o;
            if (acc_now) exp_q.push_back(16'(a_i) * 16'(b_i));
            tick();
            cyc++;
            if (acc_now) begin
                n_acc++;
                a_i = 8'($urandom_range(0, 255));
                b_i = 8'($urandom_range(0, 255));
            end
            if (cons_now) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL random_extra_output: p=%h with no outstanding operand", snap_p);
                end else begin
                    exp_p = exp_q.pop_front();
                    if (snap_p !== exp_p) begin
                        failures++;
                        bad++;
                        if (bad < 10) $display("FAIL random_product_%0d: p=%h required %h", n_out, snap_p, exp_p);
                    end
                end
                n_out++;
            end
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        checks++;
        if (n_out != 1000 || n_acc != 1000 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL random_count: accepted=%0d produced=%0d pending=%0d, required 1000 1000 0", n_acc, n_out, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_corners();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
